// File: rtl/core_pkg.sv
// Shared core definitions for the ID/EX stage: forward selects, ALU control
// width, the ID/EX control bundle and the update-action encoding.
package core_pkg;

    localparam int ALUCTRL_W = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef struct packed {
        logic                 regwrite;
        logic                 memtoreg;
        logic                 memwrite;
        logic                 alusrc;
        logic [ALUCTRL_W-1:0] aluctrl;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_CTRL_BUBBLE = '0;

    // What the ID/EX register does on the coming edge (reset handled separately)
    typedef enum logic [1:0] {
        UPD_LOAD  = 2'b00,
        UPD_HOLD  = 2'b01,
        UPD_STALL = 2'b10,
        UPD_FLUSH = 2'b11
    } idex_upd_t;

    // An empty ID slot must never write state, so its control collapses to a bubble
    function automatic idex_ctrl_t gate_ctrl(input idex_ctrl_t c, input logic valid);
        return valid ? c : IDEX_CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/idex_stage_fwd_mux3.sv
// XLEN-wide 3:1 forwarding select; the reserved encoding falls back to the
// register value.
module fwd_mux3
    import core_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] regval,
    input  logic [W-1:0] mval,
    input  logic [W-1:0] wval,
    output logic [W-1:0] y
);

    always_comb begin
        y = regval;
        case (sel)
            FWD_M:   y = mval;
            FWD_W:   y = wval;
            default: y = regval;
        endcase
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register of the RV32 core with EX-side operand forwarding.
// Optional perf counters (bubble_cnt, flush_cnt) when IDEX_PERF_CNT_EN is defined.
module idex_stage
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RFIDX_W   = 5,
    parameter int ALUCTRL_W = core_pkg::ALUCTRL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 writen,
    input  logic                 flushE,
    input  logic                 holdE,
    input  logic                 validD,
    input  logic [XLEN-1:0]      pcD,
    input  logic [XLEN-1:0]      rd1D,
    input  logic [XLEN-1:0]      rd2D,
    input  logic [XLEN-1:0]      immD,
    input  logic [RFIDX_W-1:0]   rs1D,
    input  logic [RFIDX_W-1:0]   rs2D,
    input  logic [RFIDX_W-1:0]   rdD,
    input  logic                 regwriteD,
    input  logic                 memtoregD,
    input  logic                 memwriteD,
    input  logic                 alusrcD,
    input  logic [ALUCTRL_W-1:0] aluctrlD,
    input  logic [1:0]           forwardA,
    input  logic [1:0]           forwardB,
    input  logic [XLEN-1:0]      aluresultM,
    input  logic [XLEN-1:0]      resultW,
    output logic                 validE,
    output logic [XLEN-1:0]      pcE,
    output logic [XLEN-1:0]      immE,
    output logic [RFIDX_W-1:0]   rs1E,
    output logic [RFIDX_W-1:0]   rs2E,
    output logic [RFIDX_W-1:0]   rdE,
    output logic                 regwriteE,
    output logic                 memtoregE,
    output logic                 memwriteE,
    output logic [ALUCTRL_W-1:0] aluctrlE,
    output logic [XLEN-1:0]      srcAE,
    output logic [XLEN-1:0]      srcBE,
    output logic [XLEN-1:0]      writedataE
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]          bubble_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    idex_ctrl_t      ctrlD;
    idex_ctrl_t      ctrlE;
    idex_upd_t       upd;
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [XLEN-1:0] fwdA;
    logic [XLEN-1:0] fwdB;

    assign ctrlD = '{regwrite: regwriteD,
                     memtoreg: memtoregD,
                     memwrite: memwriteD,
                     alusrc:   alusrcD,
                     aluctrl:  aluctrlD};

    // Flush beats hold so a killed instruction never lingers; hold beats a
    // stall because the hazard unit re-evaluates once EX is free again.
    always_comb begin
        upd = UPD_LOAD;
        if (flushE)
            upd = UPD_FLUSH;
        else if (holdE)
            upd = UPD_HOLD;
        else if (!writen)
            upd = UPD_STALL;
    end

    // Bubbles zero rdE (never forwarded) and memtoregE (ends the load-use condition).
    always_ff @(posedge clk) begin
        if (rst || upd == UPD_FLUSH || upd == UPD_STALL) begin
            validE <= 1'b0;
            ctrlE  <= IDEX_CTRL_BUBBLE;
            pcE    <= '0;
            immE   <= '0;
            rd1E   <= '0;
            rd2E   <= '0;
            rs1E   <= '0;
            rs2E   <= '0;
            rdE    <= '0;
        end else if (upd == UPD_LOAD) begin
            validE <= validD;
            ctrlE  <= gate_ctrl(ctrlD, validD);
            pcE    <= pcD;
            immE   <= immD;
            rd1E   <= rd1D;
            rd2E   <= rd2D;
            rs1E   <= rs1D;
            rs2E   <= rs2D;
            rdE    <= validD ? rdD : '0;
        end
    end

    assign regwriteE = ctrlE.regwrite;
    assign memtoregE = ctrlE.memtoreg;
    assign memwriteE = ctrlE.memwrite;
    assign aluctrlE  = ctrlE.aluctrl;

    fwd_mux3 #(.W(XLEN)) u_fwd_a (
        .sel    (forwardA),
        .regval (rd1E),
        .mval   (aluresultM),
        .wval   (resultW),
        .y      (fwdA)
    );

    fwd_mux3 #(.W(XLEN)) u_fwd_b (
        .sel    (forwardB),
        .regval (rd2E),
        .mval   (aluresultM),
        .wval   (resultW),
        .y      (fwdB)
    );

    assign srcAE      = fwdA;
    assign writedataE = fwdB;
    assign srcBE      = ctrlE.alusrc ? immE : fwdB;

`ifdef IDEX_PERF_CNT_EN
    // Only stalls that actually insert a bubble count; a stall masked by hold does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (upd == UPD_STALL)
                bubble_cnt <= bubble_cnt + 32'd1;
            if (flushE)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
